// File: rtl/ksa_4bit_pkg.sv
// Shared definitions for the adders library: prefix-tree node type and
// the stage-count helper used to size the Kogge-Stone tree.
package ksa_4bit_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 <<< k) < value) begin
                result = k + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ksa_4bit_prefix_cell.sv
// Black cell of the prefix tree: merges a high-order (G,P) group with the
// adjacent low-order group into one wider group.
module ksa_prefix_cell
    import ksa_4bit_pkg::*;
(
    input  gp_t i_hi,
    input  gp_t i_lo,
    output gp_t o_gp
);

    assign o_gp.g = i_hi.g | (i_hi.p & i_lo.g);
    assign o_gp.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/ksa_4bit.sv
// Registered Kogge-Stone adder: {cout,sum} = a + b + cin, one cycle latency,
// result register loads only on in_valid.
module ksa_4bit
    import ksa_4bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int STAGES = clog2(WIDTH);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    gp_t              w_cin_gp;
    gp_t              w_tree [0:STAGES][0:WIDTH-1];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    assign w_g      = a & b;
    assign w_p      = a ^ b;
    assign w_cin_gp = {cin, 1'b0};

    // Carry-in sits at position -1; folding it into bit 0 up front keeps the
    // tree at exactly log2(WIDTH) combine levels.
    for (genvar i = 0; i < WIDTH; i++) begin : gen_pre
        if (i == 0) begin : gen_fold
            ksa_prefix_cell u_fold (
                .i_hi ({w_g[i], w_p[i]}),
                .i_lo (w_cin_gp),
                .o_gp (w_tree[0][i])
            );
        end else begin : gen_leaf
            assign w_tree[0][i] = {w_g[i], w_p[i]};
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : gen_stage
        localparam int SPAN = 32'sd1 <<< s;
        for (genvar i = 0; i < WIDTH; i++) begin : gen_node
            if (i < SPAN) begin : gen_buf
                assign w_tree[s+1][i] = w_tree[s][i];
            end else if (s == STAGES - 1) begin : gen_gray
                assign w_tree[s+1][i] = {w_tree[s][i].g | (w_tree[s][i].p & w_tree[s][i-SPAN].g), 1'b0};
            end else begin : gen_black
                ksa_prefix_cell u_cell (
                    .i_hi (w_tree[s][i]),
                    .i_lo (w_tree[s][i-SPAN]),
                    .o_gp (w_tree[s+1][i])
                );
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gen_carry
        if (i == 0) begin : gen_c0
            assign w_carry[i] = cin;
        end else begin : gen_ci
            assign w_carry[i] = w_tree[STAGES][i-1].g;
        end
    end

    assign w_sum  = w_p ^ w_carry;
    assign w_cout = w_tree[STAGES][WIDTH-1].g;

    // Result register: valid strobe follows in_valid, data holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ksa_4bit.sv
// Self-checking bench for ksa_4bit: directed table, valid gating, reset
// corners, exhaustive sweep and randomized traffic against an arithmetic model.
module tb_ksa_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [6];

    ksa_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_add(input logic [3:0] x, input logic [3:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] e_sum, input logic e_cout, input logic e_valid);
        n_checks++;
        if (sum !== e_sum || cout !== e_cout || out_valid !== e_valid) begin
            n_errors++;
            $display("FAIL %s: got sum=%h cout=%b out_valid=%b, expected sum=%h cout=%b out_valid=%b",
                     name, sum, cout, out_valid, e_sum, e_cout, e_valid);
        end
    endtask

    initial begin
        logic [4:0] exp_r;
        logic [3:0] exp_sum;
        logic       exp_cout;
        logic       v;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [8:0] n9;

        vecs[0] = '{a: 4'h0, b: 4'h0, cin: 1'b0, sum: 4'h0, cout: 1'b0};
        vecs[1] = '{a: 4'h3, b: 4'h5, cin: 1'b0, sum: 4'h8, cout: 1'b0};
        vecs[2] = '{a: 4'hF, b: 4'h1, cin: 1'b0, sum: 4'h0, cout: 1'b1};
        vecs[3] = '{a: 4'hA, b: 4'h5, cin: 1'b1, sum: 4'h0, cout: 1'b1};
        vecs[4] = '{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 4'hF, cout: 1'b1};
        vecs[5] = '{a: 4'hF, b: 4'h0, cin: 1'b1, sum: 4'h0, cout: 1'b1};

        // Reset held with valid operands applied: outputs must stay cleared.
        rst_n = 1'b0;
        drive(1'b1, 4'h3, 4'h5, 1'b0);
        #2;
        check("reset_async", 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_hold", 4'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        check("first_after_release", 4'h8, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            drive(1'b1, vecs[k].a, vecs[k].b, vecs[k].cin);
            tick();
            check($sformatf("table_%0d", k), vecs[k].sum, vecs[k].cout, 1'b1);
        end

        // Valid gating: idle cycles with changing operands must hold data.
        drive(1'b1, 4'h7, 4'h6, 1'b1);
        tick();
        check("gate_load", 4'hE, 1'b0, 1'b1);
        drive(1'b0, 4'h1, 4'h2, 1'b0);
        tick();
        check("gate_idle1", 4'hE, 1'b0, 1'b0);
        drive(1'b0, 4'hF, 4'hF, 1'b1);
        tick();
        check("gate_idle2", 4'hE, 1'b0, 1'b0);

        // Reset mid-cycle: clears without an edge, then stays clear while idle.
        drive(1'b1, 4'h9, 4'h9, 1'b0);
        tick();
        check("pre_reset", 4'h2, 1'b1, 1'b1);
        drive(1'b1, 4'h4, 4'h4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midcycle", 4'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 4'h4, 4'h4, 1'b0);
        tick();
        check("after_reset_idle", 4'h0, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 4'h3, 1'b1);
        tick();
        check("after_reset_first", 4'h6, 1'b0, 1'b1);

        // Exhaustive sweep, back-to-back.
        for (int n = 0; n < 512; n++) begin
            n9 = 9'(n);
            drive(1'b1, n9[3:0], n9[7:4], n9[8]);
            exp_r = model_add(n9[3:0], n9[7:4], n9[8]);
            tick();
            check($sformatf("exh_%0d", n), exp_r[3:0], exp_r[4], 1'b1);
        end

        // Random traffic with gaps; model tracks last accepted result.
        exp_sum  = exp_r[3:0];
        exp_cout = exp_r[4];
        for (int n = 0; n < 300; n++) begin
            v  = 1'($urandom_range(0, 1));
            ra = 4'($urandom);
            rb = 4'($urandom);
            rc = 1'($urandom);
            drive(v, ra, rb, rc);
            if (v) begin
                exp_r    = model_add(ra, rb, rc);
                exp_sum  = exp_r[3:0];
                exp_cout = exp_r[4];
            end
            tick();
            check($sformatf("rand_%0d", n), exp_sum, exp_cout, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
